mac_t_gmii: RTL and testbench

//  GMII transmit MAC for the switch egress port: the transmit counterpart of the mac_r_gmii receive path.

---
 rtl/mac_t_gmii_pkg.sv | 37 +++
 rtl/mac_t_gmii_if.sv | 32 +++
 rtl/mac_t_gmii_crc32_d8.sv | 12 +
 rtl/mac_t_gmii.sv | 240 ++++++++++++++++++++++++
 tb/tb_mac_t_gmii.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_t_gmii_pkg.sv
// Shared constants, FSM state type and byte-wide CRC-32 step for the GMII transmit MAC.
package mac_t_gmii_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY_R  = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [10:0] PRE_LAST      = 11'd6;
  localparam logic [1:0]  FCS_LAST      = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_LOAD = 4'd1,
    ST_PRE  = 4'd2,
    ST_SFD  = 4'd3,
    ST_DATA = 4'd4,
    ST_PAD  = 4'd5,
    ST_FCS  = 4'd6,
    ST_IFG  = 4'd7,
    ST_DROP = 4'd8
  } tx_state_e;

  // Reflected CRC-32: eight LSB-first LFSR steps for one byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if ((c[0] ^ data[i]) == 1'b1) begin
        c = (c >> 1) ^ CRC32_POLY_R;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_t_gmii_if.sv
// FIFO-side and GMII-side signal bundle of the transmit MAC; master = MAC, slave = FIFOs/PHY.
interface mac_t_gmii_if;

  logic        ptr_fifo_empty;
  logic        ptr_fifo_rd;
  logic [15:0] ptr_fifo_dout;
  logic        data_fifo_rd;
  logic [7:0]  data_fifo_dout;
  logic        tx_en;
  logic [7:0]  gm_tx_d;

  modport master (
    input  ptr_fifo_empty,
    input  ptr_fifo_dout,
    input  data_fifo_dout,
    output ptr_fifo_rd,
    output data_fifo_rd,
    output tx_en,
    output gm_tx_d
  );

  modport slave (
    output ptr_fifo_empty,
    output ptr_fifo_dout,
    output data_fifo_dout,
    input  ptr_fifo_rd,
    input  data_fifo_rd,
    input  tx_en,
    input  gm_tx_d
  );

endinterface

// File: rtl/mac_t_gmii_crc32_d8.sv
// crc32_d8: combinational next-CRC for one byte; shared with the receive-path checker.
module crc32_d8
  import mac_t_gmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  assign crc_out = crc32_byte(crc_in, data_in);

endmodule

// File: rtl/mac_t_gmii.sv
// GMII transmit MAC: descriptor pop, preamble/SFD, payload, zero pad, FCS and inter-frame gap.
// Optional SFD egress timestamp is built when TX_TIMESTAMP_EN is defined.
module mac_t_gmii
  import mac_t_gmii_pkg::*;
#(
  parameter int MIN_LEN   = 60,
  parameter int MAX_LEN   = 1514,
  parameter int IFG_BYTES = 12
) (
  input  logic                clk,
  input  logic                rst,
  mac_t_gmii_if.master        bus,
  output logic                tx_busy,
  output logic                frame_done,
  output logic                frame_drop,
  input  logic [31:0]         counter_ns,
  output logic [31:0]         tx_ts,
  output logic                tx_ts_valid
);

  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
  localparam logic [10:0] PAD_LAST = 11'(MIN_LEN - 1);
  localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);

  tx_state_e   state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;

  logic [10:0] len_last_s;
  logic [31:0] fcs_s;
  logic [7:0]  crc_byte_s;
  logic [31:0] crc_next_s;
  logic        ptr_rd_s;
  logic        data_rd_s;
  logic        tx_en_s;
  logic [7:0]  txd_s;
  logic        done_s;
  logic        drop_s;

  assign len_last_s = len_q - 11'd1;
  assign fcs_s      = ~crc_q;
  // Pad bytes are zeros on the wire, so the CRC must see zeros rather than stale FIFO data.
  assign crc_byte_s = (state_q == ST_PAD) ? 8'h00 : bus.data_fifo_dout;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data_in (crc_byte_s),
    .crc_out (crc_next_s)
  );

  // State, byte counter, latched length and running CRC
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 11'd0;
      len_q   <= 11'd0;
      crc_q   <= CRC32_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      crc_q   <= crc_d;
    end
  end

  // Next-state and per-cycle output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    crc_d     = crc_q;
    ptr_rd_s  = 1'b0;
    data_rd_s = 1'b0;
    tx_en_s   = 1'b0;
    txd_s     = 8'h00;
    done_s    = 1'b0;
    drop_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 11'd0;
        if (!bus.ptr_fifo_empty) begin
          ptr_rd_s = 1'b1;
          state_d  = ST_LOAD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        len_d = bus.ptr_fifo_dout[10:0];
        cnt_d = 11'd0;
        crc_d = CRC32_INIT;
        if (bus.ptr_fifo_dout[10:0] == 11'd0) begin
          drop_s  = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.ptr_fifo_dout[10:0] > MAX_L) begin
          state_d = ST_DROP;
        end else begin
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        tx_en_s = 1'b1;
        txd_s   = PREAMBLE_BYTE;
        if (cnt_q == PRE_LAST) begin
          cnt_d   = 11'd0;
          state_d = ST_SFD;
        end else begin
          cnt_d   = cnt_q + 11'd1;
        end
      end
      ST_SFD: begin
        tx_en_s   = 1'b1;
        txd_s     = SFD_BYTE;
        data_rd_s = 1'b1;
        cnt_d     = 11'd0;
        state_d   = ST_DATA;
      end
      ST_DATA: begin
        tx_en_s = 1'b1;
        txd_s   = bus.data_fifo_dout;
        crc_d   = crc_next_s;
        if (cnt_q == len_last_s) begin
          if (len_q < MIN_L) begin
            cnt_d   = len_q;
            state_d = ST_PAD;
          end else begin
            cnt_d   = 11'd0;
            state_d = ST_FCS;
          end
        end else begin
          data_rd_s = 1'b1;
          cnt_d     = cnt_q + 11'd1;
        end
      end
      ST_PAD: begin
        tx_en_s = 1'b1;
        txd_s   = 8'h00;
        crc_d   = crc_next_s;
        if (cnt_q == PAD_LAST) begin
          cnt_d   = 11'd0;
          state_d = ST_FCS;
        end else begin
          cnt_d   = cnt_q + 11'd1;
        end
      end
      ST_FCS: begin
        tx_en_s = 1'b1;
        case (cnt_q[1:0])
          2'd0:    txd_s = fcs_s[7:0];
          2'd1:    txd_s = fcs_s[15:8];
          2'd2:    txd_s = fcs_s[23:16];
          2'd3:    txd_s = fcs_s[31:24];
          default: txd_s = 8'h00;
        endcase
        if (cnt_q[1:0] == FCS_LAST) begin
          done_s  = 1'b1;
          cnt_d   = 11'd0;
          state_d = ST_IFG;
        end else begin
          cnt_d   = cnt_q + 11'd1;
        end
      end
      ST_IFG: begin
        if (cnt_q == IFG_LAST) begin
          cnt_d   = 11'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 11'd1;
        end
      end
      ST_DROP: begin
        data_rd_s = 1'b1;
        if (cnt_q == len_last_s) begin
          drop_s  = 1'b1;
          cnt_d   = 11'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 11'd1;
        end
      end
      default: begin
        cnt_d   = 11'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pops are masked during reset so a mid-frame reset never consumes an extra entry.
  assign bus.ptr_fifo_rd  = ptr_rd_s & ~rst;
  assign bus.data_fifo_rd = data_rd_s & ~rst;
  assign bus.tx_en        = tx_en_s;
  assign bus.gm_tx_d      = tx_en_s ? txd_s : 8'h00;
  assign tx_busy          = (state_q != ST_IDLE);
  assign frame_done       = done_s;
  assign frame_drop       = drop_s;

`ifdef TX_TIMESTAMP_EN
  logic [31:0] tx_ts_q, tx_ts_d;
  logic        tx_ts_valid_q, tx_ts_valid_d;
  logic        unused_s;

  assign unused_s = ^bus.ptr_fifo_dout[15:11];

  // Capture the time base while the SFD is on the wire
  always_comb begin
    tx_ts_d       = tx_ts_q;
    tx_ts_valid_d = 1'b0;
    if (state_q == ST_SFD) begin
      tx_ts_d       = counter_ns;
      tx_ts_valid_d = 1'b1;
    end else begin
      tx_ts_d       = tx_ts_q;
      tx_ts_valid_d = 1'b0;
    end
  end

  // Timestamp registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ts_q       <= 32'h0000_0000;
      tx_ts_valid_q <= 1'b0;
    end else begin
      tx_ts_q       <= tx_ts_d;
      tx_ts_valid_q <= tx_ts_valid_d;
    end
  end

  assign tx_ts       = tx_ts_q;
  assign tx_ts_valid = tx_ts_valid_q;
`else
  logic unused_s;

  assign unused_s    = ^{bus.ptr_fifo_dout[15:11], counter_ns};
  assign tx_ts       = 32'h0000_0000;
  assign tx_ts_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mac_t_gmii.sv
// Directed bench for mac_t_gmii: FIFO models, GMII capture monitor and per-scenario checks.
module tb_mac_t_gmii;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_busy, frame_done, frame_drop, tx_ts_valid;
  logic [31:0] counter_ns, tx_ts;
  logic [31:0] cyc = 32'd0;

  int vectors = 0;
  int miscompares = 0;

  mac_t_gmii_if bus ();

  mac_t_gmii dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .tx_busy     (tx_busy),
    .frame_done  (frame_done),
    .frame_drop  (frame_drop),
    .counter_ns  (counter_ns),
    .tx_ts       (tx_ts),
    .tx_ts_valid (tx_ts_valid)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;
  assign counter_ns = cyc * 32'd5;

  // FIFO models: pop on posedge, data valid the following cycle, flushed by rst
  logic [15:0] ptr_mem [0:15];
  logic [7:0]  data_mem [0:8191];
  int          ptr_wr = 0, ptr_rd = 0, data_wr = 0, data_rd = 0, data_pops = 0;
  logic [15:0] ptr_dout = 16'h0;
  logic [7:0]  data_dout = 8'h0;

  assign bus.ptr_fifo_empty = (ptr_wr == ptr_rd);
  assign bus.ptr_fifo_dout  = ptr_dout;
  assign bus.data_fifo_dout = data_dout;

  always @(posedge clk) begin
    if (rst) begin
      ptr_rd  <= ptr_wr;
      data_rd <= data_wr;
    end else begin
      if (bus.ptr_fifo_rd) begin
        ptr_dout <= ptr_mem[ptr_rd % 16];
        ptr_rd   <= ptr_rd + 1;
      end
      if (bus.data_fifo_rd) begin
        data_dout <= data_mem[data_rd % 8192];
        data_rd   <= data_rd + 1;
        data_pops <= data_pops + 1;
      end
    end
  end

  // GMII monitor: captures bytes, frame boundaries, idle gaps and pulse counts
  logic [7:0] cap [0:8191];
  int fstart [0:31];
  int flen [0:31];
  int fgap [0:31];
  int fcnt = 0, cap_n = 0, cur_len = 0, idle_run = 0;
  int done_cnt = 0, drop_cnt = 0, ts_cnt = 0, ptr_rd_busy = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    prev_en <= bus.tx_en;
    if (bus.tx_en) begin
      cap[cap_n % 8192] <= bus.gm_tx_d;
      cap_n <= cap_n + 1;
      if (!prev_en) begin
        fstart[fcnt % 32] <= cap_n;
        fgap[fcnt % 32]   <= idle_run;
        cur_len           <= 1;
      end else begin
        cur_len <= cur_len + 1;
      end
    end else begin
      if (prev_en) begin
        flen[fcnt % 32] <= cur_len;
        fcnt            <= fcnt + 1;
        idle_run        <= 1;
      end else begin
        idle_run <= idle_run + 1;
      end
    end
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_drop) drop_cnt <= drop_cnt + 1;
    if (tx_ts_valid) ts_cnt <= ts_cnt + 1;
    if (bus.ptr_fifo_rd && tx_busy) ptr_rd_busy <= ptr_rd_busy + 1;
  end

  logic [7:0] pay_buf [0:2047];
  logic [7:0] msg [0:2047];
  logic [7:0] exp_b [0:4095];

  // Reference FCS: MSB-first CRC on bit-reversed input, reversed and inverted at the end
  function automatic logic [31:0] calc_crc(input int n);
    logic [31:0] c, r;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[31] ^ msg[k][i];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C11DB7;
      end
    end
    for (int i = 0; i < 32; i++) r[i] = c[31 - i];
    return ~r;
  endfunction

  task automatic push_ptr(input logic [15:0] v);
    ptr_mem[ptr_wr % 16] = v;
    ptr_wr = ptr_wr + 1;
  endtask

  task automatic push_frame(input int len, input logic [7:0] base, input bit hdr, input logic [4:0] hi);
    logic [7:0] hd [0:13];
    hd = '{8'hf0, 8'hf1, 8'hf2, 8'hf3, 8'hf4, 8'hf5,
           8'he0, 8'he1, 8'he2, 8'he3, 8'he4, 8'he5, 8'h88, 8'hf7};
    for (int i = 0; i < len; i++) begin
      pay_buf[i] = (hdr && i < 14) ? hd[i] : 8'(base + i * 3);
      data_mem[data_wr % 8192] = pay_buf[i];
      data_wr = data_wr + 1;
    end
    push_ptr({hi, 11'(len)});
  endtask

  task automatic build_exp(input int len, input int off, output int n);
    int          tot;
    logic [31:0] f;
    tot = (len < 60) ? 60 : len;
    for (int i = 0; i < tot; i++) msg[i] = (i < len) ? pay_buf[i] : 8'h00;
    f = calc_crc(tot);
    n = 0;
    for (int i = 0; i < 7; i++) begin exp_b[off + n] = 8'h55; n++; end
    exp_b[off + n] = 8'hD5; n++;
    for (int i = 0; i < tot; i++) begin exp_b[off + n] = msg[i]; n++; end
    for (int b = 0; b < 4; b++) begin exp_b[off + n] = f[8 * b +: 8]; n++; end
  endtask

  function automatic int first_diff(input int start, input int off, input int n);
    for (int i = 0; i < n; i++) begin
      if (cap[(start + i) % 8192] !== exp_b[off + i]) return i;
    end
    return -1;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int c = 0; c < budget && fcnt < target; c++) step();
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      if (!tx_busy && bus.ptr_fifo_empty) break;
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) step();
    vectors++;
    if ({bus.tx_en, bus.ptr_fifo_rd, bus.data_fifo_rd, tx_busy, frame_done, frame_drop, tx_ts_valid} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0000000", {bus.tx_en, bus.ptr_fifo_rd, bus.data_fifo_rd, tx_busy, frame_done, frame_drop, tx_ts_valid});
    end
    vectors++;
    if (bus.gm_tx_d !== 8'h00) begin miscompares++; $display("FAIL reset_txd: got %h want 00", bus.gm_tx_d); end
    vectors++;
    if (tx_ts !== 32'h0) begin miscompares++; $display("FAIL reset_ts: got %h want 0", tx_ts); end
    rst = 1'b0;
    repeat (2) step();
    vectors++;
    if (tx_busy !== 1'b0 || bus.tx_en !== 1'b0) begin
      miscompares++; $display("FAIL idle_after_reset: busy %b tx_en %b want 0 0", tx_busy, bus.tx_en);
    end
  endtask

  task automatic test_frame_100();
    int f0, d0, p0, n, bad;
    f0 = fcnt; d0 = done_cnt; p0 = data_pops;
    push_frame(100, 8'h10, 1'b1, 5'b00000);
    build_exp(100, 0, n);
    wait_frames(f0 + 1, 400);
    vectors++;
    if (fcnt != f0 + 1) begin miscompares++; $display("FAIL f100_count: got %0d frames want 1", fcnt - f0); end
    vectors++;
    if (flen[f0 % 32] != 112) begin miscompares++; $display("FAIL f100_len: got %0d want 112", flen[f0 % 32]); end
    bad = first_diff(fstart[f0 % 32], 0, n);
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL f100_bytes: at %0d got %h want %h", bad, cap[(fstart[f0 % 32] + bad) % 8192], exp_b[bad]);
    end
    vectors++;
    if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL f100_done: got %0d pulses want 1", done_cnt - d0); end
    vectors++;
    if (data_pops - p0 != 100) begin miscompares++; $display("FAIL f100_pops: got %0d want 100", data_pops - p0); end
    wait_idle();
  endtask

  task automatic test_pad_40();
    int f0, p0, n, bad;
    f0 = fcnt; p0 = data_pops;
    push_frame(40, 8'h07, 1'b0, 5'b10101);
    build_exp(40, 0, n);
    wait_frames(f0 + 1, 300);
    vectors++;
    if (flen[f0 % 32] != 72) begin miscompares++; $display("FAIL pad_len: got %0d want 72", flen[f0 % 32]); end
    bad = first_diff(fstart[f0 % 32], 0, n);
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL pad_bytes: at %0d got %h want %h", bad, cap[(fstart[f0 % 32] + bad) % 8192], exp_b[bad]);
    end
    wait_idle();
    vectors++;
    if (data_pops - p0 != 40) begin miscompares++; $display("FAIL pad_pops: got %0d want 40", data_pops - p0); end
  endtask

  task automatic test_back_to_back();
    int f0, b0, na, nb, bad;
    f0 = fcnt; b0 = ptr_rd_busy;
    push_frame(64, 8'h33, 1'b0, 5'b00000);
    build_exp(64, 0, na);
    push_frame(61, 8'h77, 1'b0, 5'b00000);
    build_exp(61, na, nb);
    wait_frames(f0 + 2, 600);
    vectors++;
    if (flen[f0 % 32] != 76 || flen[(f0 + 1) % 32] != 73) begin
      miscompares++; $display("FAIL b2b_len: got %0d,%0d want 76,73", flen[f0 % 32], flen[(f0 + 1) % 32]);
    end
    bad = first_diff(fstart[f0 % 32], 0, na);
    vectors++;
    if (bad >= 0) begin miscompares++; $display("FAIL b2b_bytes_a: at %0d got %h want %h", bad, cap[(fstart[f0 % 32] + bad) % 8192], exp_b[bad]); end
    bad = first_diff(fstart[(f0 + 1) % 32], na, nb);
    vectors++;
    if (bad >= 0) begin miscompares++; $display("FAIL b2b_bytes_b: at %0d got %h want %h", bad, cap[(fstart[(f0 + 1) % 32] + bad) % 8192], exp_b[na + bad]); end
    vectors++;
    if (fgap[(f0 + 1) % 32] != 14) begin miscompares++; $display("FAIL b2b_gap: got %0d idle cycles want 14", fgap[(f0 + 1) % 32]); end
    wait_idle();
    vectors++;
    if (ptr_rd_busy != b0) begin miscompares++; $display("FAIL b2b_ptr_rd_busy: got %0d want 0", ptr_rd_busy - b0); end
  endtask

  task automatic test_drop();
    int f0, d0, p0, n, bad;
    f0 = fcnt; d0 = drop_cnt; p0 = data_pops;
    push_frame(1515, 8'h5A, 1'b0, 5'b00000);
    push_frame(60, 8'hA5, 1'b0, 5'b00000);
    build_exp(60, 0, n);
    wait_frames(f0 + 1, 2500);
    wait_idle();
    vectors++;
    if (drop_cnt - d0 != 1) begin miscompares++; $display("FAIL drop_pulse: got %0d want 1", drop_cnt - d0); end
    vectors++;
    if (fcnt - f0 != 1 || flen[f0 % 32] != 72) begin
      miscompares++; $display("FAIL drop_frames: got %0d frames len %0d want 1 len 72", fcnt - f0, flen[f0 % 32]);
    end
    bad = first_diff(fstart[f0 % 32], 0, n);
    vectors++;
    if (bad >= 0) begin miscompares++; $display("FAIL drop_next_bytes: at %0d got %h want %h", bad, cap[(fstart[f0 % 32] + bad) % 8192], exp_b[bad]); end
    vectors++;
    if (data_pops - p0 != 1575) begin miscompares++; $display("FAIL drop_pops: got %0d want 1575", data_pops - p0); end
    // zero-length descriptor with the ignored upper bits set
    f0 = fcnt; d0 = drop_cnt; p0 = data_pops;
    push_ptr(16'hF800);
    for (int c = 0; c < 20 && drop_cnt == d0; c++) step();
    repeat (20) step();
    vectors++;
    if (drop_cnt - d0 != 1 || data_pops != p0 || fcnt != f0) begin
      miscompares++;
      $display("FAIL len0: drops %0d pops %0d frames %0d want 1 0 0", drop_cnt - d0, data_pops - p0, fcnt - f0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int f0, k, n, bad;
    f0 = fcnt; k = 0;
    push_frame(100, 8'h21, 1'b0, 5'b00000);
    for (int c = 0; c < 300 && k < 39; c++) begin
      step();
      if (bus.tx_en) k++;
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({bus.tx_en, bus.ptr_fifo_rd, bus.data_fifo_rd, tx_busy, frame_done, frame_drop, bus.gm_tx_d} !== 14'b0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got tx_en %b busy %b txd %h want all 0", bus.tx_en, tx_busy, bus.gm_tx_d);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (flen[f0 % 32] != 39 || cap[(fstart[f0 % 32] + 38) % 8192] !== pay_buf[30]) begin
      miscompares++;
      $display("FAIL midrst_trunc: len %0d last %h want 39 %h", flen[f0 % 32], cap[(fstart[f0 % 32] + 38) % 8192], pay_buf[30]);
    end
    push_frame(60, 8'h44, 1'b0, 5'b00000);
    build_exp(60, 0, n);
    wait_frames(f0 + 2, 300);
    vectors++;
    if (flen[(f0 + 1) % 32] != 72) begin miscompares++; $display("FAIL postrst_len: got %0d want 72", flen[(f0 + 1) % 32]); end
    bad = first_diff(fstart[(f0 + 1) % 32], 0, n);
    vectors++;
    if (bad >= 0) begin miscompares++; $display("FAIL postrst_bytes: at %0d got %h want %h", bad, cap[(fstart[(f0 + 1) % 32] + bad) % 8192], exp_b[bad]); end
    wait_idle();
  endtask

  task automatic test_timestamp();
    int t0;
    t0 = ts_cnt;
`ifdef TX_TIMESTAMP_EN
    begin
      logic [31:0] exp_ts;
      bit          seen;
      seen = 1'b0;
      exp_ts = 32'h0;
      push_frame(60, 8'h99, 1'b0, 5'b00000);
      for (int c = 0; c < 50 && !seen; c++) begin
        step();
        if (bus.tx_en && bus.gm_tx_d == 8'hD5) begin seen = 1'b1; exp_ts = counter_ns; end
      end
      step();
      vectors++;
      if (tx_ts_valid !== 1'b1 || tx_ts !== exp_ts) begin
        miscompares++; $display("FAIL ts_value: valid %b ts %h want 1 %h", tx_ts_valid, tx_ts, exp_ts);
      end
      wait_idle();
      vectors++;
      if (ts_cnt - t0 != 1) begin miscompares++; $display("FAIL ts_pulses: got %0d want 1", ts_cnt - t0); end
    end
`else
    push_frame(60, 8'h99, 1'b0, 5'b00000);
    wait_idle();
    vectors++;
    if (ts_cnt != t0 || tx_ts !== 32'h0) begin
      miscompares++; $display("FAIL ts_disabled: pulses %0d ts %h want 0 0", ts_cnt - t0, tx_ts);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_frame_100();
    test_pad_40();
    test_back_to_back();
    test_drop();
    test_reset_mid_frame();
    test_timestamp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
